rand_out_serializer: RTL and testbench

//  - Host-facing output stage of the TRNG core; drives the CPU I/O pins rand_req/rand_req_type/rand_byte/rand_valid/slow_clk.
//  - Generates slow_clk from ic_clk and samples host requests.
//  - Pops one 64-bit word from the seed (RDSEED) or DRBG (RDRAND) source.
//  - Emits 1/2/4 OUTPUT_WIDTH-bit shorts, changing only on slow_clk rising edges.

---
 rtl/rand_out_serializer.sv | 134 +++++++++++++
 tb/tb_rand_out_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/rand_out_serializer.sv
// Host-facing TRNG output stage: divides ic_clk into slow_clk, samples host requests,
// pops one word from the seed or DRBG source and serializes it as 1/2/4 shorts on slow_clk rises.
module rand_out_serializer #(
  parameter int OUTPUT_WIDTH = 16,
  parameter int WORD_WIDTH   = 64,
  parameter int SLOW_DIV     = 4,
  parameter int TIMEOUT_CYC  = 400
) (
  input  logic                    ic_clk,
  input  logic                    top_reset,
  input  logic                    rand_req,
  input  logic [2:0]              rand_req_type,
  output logic                    slow_clk,
  output logic [OUTPUT_WIDTH-1:0] rand_byte,
  output logic                    rand_valid,
  input  logic [WORD_WIDTH-1:0]   seed_data,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [WORD_WIDTH-1:0]   drbg_data,
  input  logic                    drbg_valid,
  output logic                    drbg_ready,
  output logic                    busy,
  output logic                    err_timeout
);

  localparam int CW = $clog2(SLOW_DIV);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam int OW = OUTPUT_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAITRISE, S_SEND} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [TW-1:0]           tcnt_q;
  logic [WORD_WIDTH-1:0]   shift_q;
  logic [2:0]              nshorts_q, sent_q;
  logic                    src_seed_q;
  logic                    slow_clk_q, rand_valid_q, seed_ready_q, drbg_ready_q, err_q;
  logic [OW-1:0]           rand_byte_q;
  logic                    rise, fall, accept;

  // RISE is the edge on which the counter wraps; FALL is the mid-period edge.
  assign rise   = (cnt_q == CW'(SLOW_DIV - 1));
  assign fall   = (cnt_q == CW'(SLOW_DIV / 2 - 1));
  assign accept = src_seed_q ? (seed_valid & seed_ready_q) : (drbg_valid & drbg_ready_q);

  always_comb begin
    cnt_d = rise ? '0 : cnt_q + CW'(1);
  end

  // NOTE: every register here, the word buffer included, is cleared by the async reset and
  // updated only with non-blocking assignments so all state moves together on one edge.
  always_ff @(posedge ic_clk or negedge top_reset) begin
    if (!top_reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      tcnt_q       <= '0;
      shift_q      <= '0;
      nshorts_q    <= '0;
      sent_q       <= '0;
      src_seed_q   <= 1'b0;
      slow_clk_q   <= 1'b0;
      rand_valid_q <= 1'b0;
      rand_byte_q  <= '0;
      seed_ready_q <= 1'b0;
      drbg_ready_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (rise)      slow_clk_q <= 1'b1;
      else if (fall) slow_clk_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (fall && rand_req && (rand_req_type <= 3'd5)) begin
            src_seed_q <= ~rand_req_type[0];
            nshorts_q  <= rand_req_type[2] ? 3'd4 : (rand_req_type[1] ? 3'd2 : 3'd1);
            tcnt_q     <= '0;
            state_q    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (accept) begin
            seed_ready_q <= 1'b0;
            drbg_ready_q <= 1'b0;
            shift_q      <= src_seed_q ? seed_data : drbg_data;
            state_q      <= S_WAITRISE;
          end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
            seed_ready_q <= 1'b0;
            drbg_ready_q <= 1'b0;
            err_q        <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            seed_ready_q <= src_seed_q;
            drbg_ready_q <= ~src_seed_q;
            tcnt_q       <= tcnt_q + TW'(1);
          end
        end
        S_WAITRISE: begin
          // Entered after the accept edge, so a word taken on a RISE waits a full period.
          if (rise) begin
            rand_byte_q  <= shift_q[OW-1:0];
            rand_valid_q <= 1'b1;
            sent_q       <= 3'd1;
            state_q      <= S_SEND;
          end
        end
        S_SEND: begin
          if (rise) begin
            if (sent_q < nshorts_q) begin
              shift_q     <= shift_q >> OW;
              rand_byte_q <= shift_q[2*OW-1:OW];
              sent_q      <= sent_q + 3'd1;
            end else begin
              rand_valid_q <= 1'b0;
              rand_byte_q  <= '0;
              state_q      <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign slow_clk    = slow_clk_q;
  assign rand_byte   = rand_byte_q;
  assign rand_valid  = rand_valid_q;
  assign seed_ready  = seed_ready_q;
  assign drbg_ready  = drbg_ready_q;
  assign busy        = (state_q != S_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_rand_out_serializer.sv
// Self-checking bench for rand_out_serializer: table vectors, hand-written corner sequences
// and randomized requests compared against a slow-period level reference model.
module tb_rand_out_serializer;
  localparam int OW = 16, WW = 64, DIV = 4, TO = 400;

  logic          ic_clk = 1'b0, top_reset = 1'b0;
  logic          rand_req = 1'b0;
  logic [2:0]    rand_req_type = 3'd0;
  logic          slow_clk, rand_valid, seed_ready, drbg_ready, busy, err_timeout;
  logic [OW-1:0] rand_byte;
  logic [WW-1:0] seed_data = '0, drbg_data = '0;
  logic          seed_valid = 1'b0, drbg_valid = 1'b0;

  rand_out_serializer #(.OUTPUT_WIDTH(OW), .WORD_WIDTH(WW), .SLOW_DIV(DIV), .TIMEOUT_CYC(TO)) dut (
    .ic_clk(ic_clk), .top_reset(top_reset), .rand_req(rand_req), .rand_req_type(rand_req_type),
    .slow_clk(slow_clk), .rand_byte(rand_byte), .rand_valid(rand_valid),
    .seed_data(seed_data), .seed_valid(seed_valid), .seed_ready(seed_ready),
    .drbg_data(drbg_data), .drbg_valid(drbg_valid), .drbg_ready(drbg_ready),
    .busy(busy), .err_timeout(err_timeout));

  always #5 ic_clk = ~ic_clk;

  int n_checks = 0, n_errors = 0;
  bit err_expected = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Handshake counters: a word is consumed on any edge where valid and ready are both high.
  int seed_pops = 0, drbg_pops = 0;
  always @(posedge ic_clk) begin
    if (seed_valid && seed_ready) seed_pops++;
    if (drbg_valid && drbg_ready) drbg_pops++;
  end

  // Divider model: slow_clk is high for the first half of each period after the first wrap.
  int m_cnt = 0, div_bad = 0;
  bit m_wrap = 1'b0;
  initial forever begin
    @(posedge ic_clk); #1;
    if (!top_reset) begin
      m_cnt = 0; m_wrap = 1'b0;
    end else begin
      m_cnt = (m_cnt + 1) % DIV;
      if (m_cnt == 0) m_wrap = 1'b1;
    end
    if (slow_clk !== (m_wrap && m_cnt < DIV / 2)) div_bad++;
  end

  task automatic tick();
    @(posedge ic_clk); #1;
  endtask

  function automatic int model_n(input logic [2:0] t);
    if (t > 3'd5) return 0;
    return (t < 3'd2) ? 1 : (t < 3'd4) ? 2 : 4;
  endfunction

  function automatic logic [15:0] model_short(input logic [63:0] w, input int i);
    return 16'((w >> (16 * i)) & 64'hFFFF);
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, " slow_clk"},    slow_clk,    0);
    check({tag, " rand_byte"},   rand_byte,   0);
    check({tag, " rand_valid"},  rand_valid,  0);
    check({tag, " seed_ready"},  seed_ready,  0);
    check({tag, " drbg_ready"},  drbg_ready,  0);
    check({tag, " busy"},        busy,        0);
    check({tag, " err_timeout"}, err_timeout, 0);
  endtask

  // One host transaction: request driven on a slow_clk rise, observed until the block is idle.
  // delay < 0 keeps the selected source empty. inject re-requests mid-SEND; do_reset resets
  // the block while the second short is on the pins.
  task automatic do_req(input string tag, input logic [2:0] rtype, input logic [63:0] word,
                        input int delay, input int exp_n, input logic [3:0][15:0] exp_s,
                        input bit exp_busy, input bit inject, input bit do_reset,
                        output int err_at);
    int rises = 0, after = 0, first_rise = -1, viol = 0, badz = 0, sp0, dp0, k;
    bit fall_seen = 0, busy_seen = 0, done = 0, sel_seed, rose, fell, prev_err;
    logic prev_slow, prev_valid;
    logic [15:0] prev_byte;
    logic [15:0] got[$];
    sel_seed = !rtype[0];
    err_at = -1;
    k = 0;
    while (!(slow_clk && !prev_slow) && k < 16) begin
      prev_slow = slow_clk; tick(); k++;
    end
    rand_req = 1'b1; rand_req_type = rtype;
    seed_data  = sel_seed ? word : ~word;
    drbg_data  = sel_seed ? ~word : word;
    seed_valid = sel_seed ? (delay == 0) : 1'b1;
    drbg_valid = sel_seed ? 1'b1 : (delay == 0);
    sp0 = seed_pops; dp0 = drbg_pops;
    prev_slow = slow_clk; prev_valid = rand_valid; prev_byte = rand_byte; prev_err = err_timeout;
    for (int cyc = 1; cyc <= 3000 && !done; cyc++) begin
      tick();
      rose = slow_clk && !prev_slow;
      fell = !slow_clk && prev_slow;
      if (fell && !fall_seen) begin fall_seen = 1; after = 0; end
      else if (fall_seen) after++;
      if (rose) begin
        rand_req = 1'b0;
        if (fall_seen) rises++;
      end
      if (!rose && (rand_byte !== prev_byte || rand_valid !== prev_valid)) viol++;
      if (!rand_valid && rand_byte !== 16'h0) badz++;
      if (busy) busy_seen = 1;
      if (err_timeout && !prev_err && err_at < 0) err_at = after;
      if (rose && rand_valid) begin
        got.push_back(rand_byte);
        if (first_rise < 0) first_rise = rises;
        if (inject && got.size() == 2) begin rand_req = 1'b1; rand_req_type = 3'd0; end
      end
      if (sel_seed) seed_valid = (delay >= 0 && cyc >= delay);
      else          drbg_valid = (delay >= 0 && cyc >= delay);
      prev_slow = slow_clk; prev_valid = rand_valid; prev_byte = rand_byte; prev_err = err_timeout;
      if (do_reset && rose && got.size() == 2) begin
        check({tag, " 2nd short before reset"}, rand_byte, exp_s[1]);
        rand_req = 1'b0;
        @(negedge ic_clk); top_reset = 1'b0; #1;
        check_all_zero({tag, " async reset"});
        err_expected = 1'b0;
        seed_valid = 1'b0; drbg_valid = 1'b0;
        repeat (3) @(negedge ic_clk);
        top_reset = 1'b1;
        k = 0;
        while (!slow_clk && k < 16) begin tick(); k++; end
        check({tag, " slow_clk restart edges"}, k, DIV);
        done = 1;
      end else if (fall_seen && after >= 8 && !busy) begin
        done = 1;
      end
    end
    rand_req = 1'b0;
    seed_valid = 1'b0; drbg_valid = 1'b0;
    check({tag, " completed"}, done, 1);
    if (!do_reset) begin
      check({tag, " shorts"}, got.size(), exp_n);
      for (int i = 0; i < exp_n && i < got.size(); i++)
        check($sformatf("%s short%0d", tag, i), got[i], exp_s[i]);
      check({tag, " selected pops"}, sel_seed ? seed_pops - sp0 : drbg_pops - dp0, (exp_n > 0) ? 1 : 0);
      check({tag, " other pops"}, sel_seed ? drbg_pops - dp0 : seed_pops - sp0, 0);
      check({tag, " off-rise changes"}, viol, 0);
      check({tag, " nonzero idle byte"}, badz, 0);
      if (delay == 0 && exp_n > 0) check({tag, " latency rises"}, first_rise, 2);
      check({tag, " busy seen"}, busy_seen, exp_busy);
      check({tag, " err_timeout"}, err_timeout, err_expected);
    end
  endtask

  typedef struct {
    logic [2:0]        rtype;
    logic [63:0]       word;
    int                delay;
    int                exp_n;
    logic [3:0][15:0]  exp_s;
  } vec_t;

  vec_t vecs[8];
  logic [3:0][15:0] ms;
  logic [63:0] w;
  logic [2:0] t;
  int ea, nn, dl;

  initial begin
    vecs[0] = '{3'd1, 64'h0123_4567_89AB_CDEF, 0,  1, {16'h0, 16'h0, 16'h0, 16'hCDEF}};
    vecs[1] = '{3'd4, 64'hDEAD_BEEF_CAFE_F00D, 0,  4, {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}};
    vecs[2] = '{3'd3, 64'h1111_2222_3333_4444, 37, 2, {16'h0, 16'h0, 16'h3333, 16'h4444}};
    vecs[3] = '{3'd2, 64'h5555_6666_7777_0000, 0,  2, {16'h0, 16'h0, 16'h7777, 16'h0000}};
    vecs[4] = '{3'd0, 64'h9999_8888_7777_6543, 5,  1, {16'h0, 16'h0, 16'h0, 16'h6543}};
    vecs[5] = '{3'd5, 64'h0F0E_0D0C_0B0A_0908, 0,  4, {16'h0F0E, 16'h0D0C, 16'h0B0A, 16'h0908}};
    vecs[6] = '{3'd6, 64'hAAAA_BBBB_CCCC_DDDD, 0,  0, '0};
    vecs[7] = '{3'd7, 64'h1234_5678_9ABC_DEF0, 0,  0, '0};

    repeat (3) @(posedge ic_clk);
    #1 check_all_zero("reset");
    @(negedge ic_clk); top_reset = 1'b1;
    repeat (6) tick();

    foreach (vecs[i])
      do_req($sformatf("vec%0d", i), vecs[i].rtype, vecs[i].word, vecs[i].delay,
             vecs[i].exp_n, vecs[i].exp_s, vecs[i].exp_n > 0, 1'b0, 1'b0, ea);

    err_expected = 1'b1;
    do_req("timeout", 3'd0, 64'h7777_7777_7777_7777, -1, 0, '0, 1'b1, 1'b0, 1'b0, ea);
    check("timeout edges after sample", ea, TO);
    do_req("after timeout", 3'd0, 64'h0000_0000_0000_BEEF, 0, 1,
           {16'h0, 16'h0, 16'h0, 16'hBEEF}, 1'b1, 1'b0, 1'b0, ea);

    do_req("inject", 3'd5, 64'h4444_3333_2222_1111, 0, 4,
           {16'h4444, 16'h3333, 16'h2222, 16'h1111}, 1'b1, 1'b1, 1'b0, ea);

    do_req("midreset", 3'd4, 64'hDEAD_BEEF_CAFE_F00D, 0, 4,
           {16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}, 1'b1, 1'b0, 1'b1, ea);
    do_req("after reset", 3'd3, 64'hFEED_FACE_0BAD_C0DE, 0, 2,
           {16'h0, 16'h0, 16'h0BAD, 16'hC0DE}, 1'b1, 1'b0, 1'b0, ea);

    for (int r = 0; r < 20; r++) begin
      t  = 3'($urandom_range(0, 7));
      w  = {$urandom, $urandom};
      dl = $urandom_range(0, 50);
      nn = model_n(t);
      for (int i = 0; i < 4; i++) ms[i] = model_short(w, i);
      do_req($sformatf("rnd%0d", r), t, w, dl, nn, ms, nn > 0, 1'b0, 1'b0, ea);
    end

    check("divider model deviations", div_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
